// File: rtl/dmac_buffer_credit_arbiter.sv
// Round-robin space-reservation arbiter for a shared DMA buffer with reserved/occupied beat accounting.
// Define DMAC_BUF_ARB_ERR_EN to build the sticky protocol-error flag; otherwise err_o is tied low.
module dmac_buffer_credit_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_ELEMENTS = 64,
  localparam int CW           = $clog2(MAX_ELEMENTS + 1),
  localparam int IW           = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*CW-1:0] req_len_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  grant_valid_o,
  input  logic                  grant_ready_i,
  output logic [IW-1:0]         grant_id_o,
  output logic [CW-1:0]         grant_len_o,
  input  logic                  wr_beat_i,
  input  logic                  pop_i,
  input  logic [CW-1:0]         pop_count_i,
  output logic [CW-1:0]         free_space_o,
  output logic [CW-1:0]         occupancy_o,
  output logic [CW-1:0]         reserved_o,
  output logic                  err_o
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_ELEMENTS);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q;
  logic [IW-1:0] rr_ptr_q;
  logic          grant_valid_q;
  logic [IW-1:0] grant_id_q;
  logic [CW-1:0] grant_len_q;
  logic [CW-1:0] reserved_q;
  logic [CW-1:0] occupancy_q;
  logic [CW-1:0] free_space_q;

  logic [CW-1:0]      len_w [NUM_REQ];
  logic [NUM_REQ-1:0] legal_w;
  logic [NUM_REQ-1:0] elig_w;
  logic               win_found_w;
  logic [IW-1:0]      win_idx_w;
  logic               accept_w;
  logic               take_w;
  logic [CW-1:0]      add_len_w;
  logic [CW-1:0]      res_plus_w;
  logic               wr_ok_w;
  logic [CW-1:0]      occ_wr_w;
  logic               pop_sat_w;
  logic [CW-1:0]      reserved_d;
  logic [CW-1:0]      occupancy_d;
  logic [CW-1:0]      free_space_d;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + IW'(1);
  endfunction

  // Illegal lengths count as eligible so they are drained and flagged instead of stalling the port.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      len_w[i]   = req_len_i[i*CW +: CW];
      legal_w[i] = (len_w[i] != '0) && (len_w[i] <= MAX_C);
      elig_w[i]  = req_valid_i[i] && (!legal_w[i] || (len_w[i] <= free_space_q));
    end
  end

  always_comb begin
    int idx;
    idx         = 0;
    win_found_w = 1'b0;
    win_idx_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found_w && elig_w[idx]) begin
        win_found_w = 1'b1;
        win_idx_w   = IW'(idx);
      end
    end
  end

  assign accept_w    = (state_q == IDLE) && !rst_i && win_found_w;
  assign take_w      = accept_w && legal_w[win_idx_w];
  assign req_ready_o = accept_w ? (NUM_REQ'(1) << win_idx_w) : '0;

  // Same-cycle reservation is added before the write converts a reserved beat to occupied.
  always_comb begin
    add_len_w    = take_w ? len_w[win_idx_w] : '0;
    res_plus_w   = reserved_q + add_len_w;
    wr_ok_w      = wr_beat_i && (res_plus_w != '0);
    reserved_d   = res_plus_w - CW'(wr_ok_w);
    occ_wr_w     = occupancy_q + CW'(wr_ok_w);
    pop_sat_w    = pop_i && (pop_count_i > occ_wr_w);
    occupancy_d  = occ_wr_w;
    if (pop_i) occupancy_d = pop_sat_w ? '0 : (occ_wr_w - pop_count_i);
    free_space_d = MAX_C - reserved_d - occupancy_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      grant_len_q   <= '0;
      reserved_q    <= '0;
      occupancy_q   <= '0;
      free_space_q  <= MAX_C;
    end else begin
      reserved_q   <= reserved_d;
      occupancy_q  <= occupancy_d;
      free_space_q <= free_space_d;
      case (state_q)
        IDLE: begin
          if (take_w) begin
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
            grant_id_q    <= win_idx_w;
            grant_len_q   <= len_w[win_idx_w];
          end else if (accept_w) begin
            // A rejected request still consumes its turn so a stuck bad requester cannot hog the pointer.
            rr_ptr_q <= next_idx(win_idx_w);
          end
        end
        GRANT: begin
          if (grant_ready_i) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= next_idx(grant_id_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DMAC_BUF_ARB_ERR_EN
  logic err_q;
  logic err_event_w;

  assign err_event_w = (accept_w && !legal_w[win_idx_w]) || (wr_beat_i && !wr_ok_w) || pop_sat_w;

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (err_event_w) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign grant_valid_o = grant_valid_q;
  assign grant_id_o    = grant_id_q;
  assign grant_len_o   = grant_len_q;
  assign reserved_o    = reserved_q;
  assign occupancy_o   = occupancy_q;
  assign free_space_o  = free_space_q;

endmodule

// File: tb/tb_dmac_buffer_credit_arbiter.sv
// Directed bench for dmac_buffer_credit_arbiter: grant scoreboard plus direct checks of buffer accounting.
module tb_dmac_buffer_credit_arbiter;

  localparam int NR = 4;
  localparam int CW = 7;
  localparam int IW = 2;
`ifdef DMAC_BUF_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*CW-1:0] req_len;
  logic [NR-1:0]  req_ready;
  logic           grant_valid;
  logic           grant_ready;
  logic [IW-1:0]  grant_id;
  logic [CW-1:0]  grant_len;
  logic           wr_beat;
  logic           pop;
  logic [CW-1:0]  pop_count;
  logic [CW-1:0]  free_space;
  logic [CW-1:0]  occupancy;
  logic [CW-1:0]  reserved;
  logic           err;

  int checks = 0;
  int errors = 0;
  logic gv_prev = 1'b0;
  logic [31:0] exp_q [$];

  dmac_buffer_credit_arbiter #(.NUM_REQ(NR), .MAX_ELEMENTS(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_len_i(req_len), .req_ready_o(req_ready),
    .grant_valid_o(grant_valid), .grant_ready_i(grant_ready),
    .grant_id_o(grant_id), .grant_len_o(grant_len),
    .wr_beat_i(wr_beat), .pop_i(pop), .pop_count_i(pop_count),
    .free_space_o(free_space), .occupancy_o(occupancy), .reserved_o(reserved),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Every new grant is popped from the scoreboard and compared as {id, len}.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (grant_valid === 1'b1 && !gv_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", {grant_id, grant_len}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", {23'd0, grant_id, grant_len}, e);
      end
    end
    gv_prev = grant_valid;
  endtask

  task automatic push(input int id, input int len);
    exp_q.push_back({23'd0, IW'(id), CW'(len)});
  endtask

  task automatic set_len(input int i, input int len);
    req_len[i*CW +: CW] = CW'(len);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_len = '0; grant_ready = 1'b0;
    wr_beat = 1'b0; pop = 1'b0; pop_count = '0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic grant_one(input int id, input int len);
    set_len(id, len);
    req_valid = NR'(1) << id;
    grant_ready = 1'b1;
    #1 chk("g1_ready", req_ready, NR'(1) << id);
    push(id, len);
    tick();
    chk("g1_valid", grant_valid, 1);
    req_valid = '0;
    tick();
    chk("g1_done", grant_valid, 0);
  endtask

  task automatic wr_beats(input int n);
    for (int i = 0; i < n; i++) begin
      wr_beat = 1'b1;
      tick();
    end
    wr_beat = 1'b0;
  endtask

  initial begin
    // Reset values, with requests pending while reset is held.
    rst = 1'b1; req_valid = '1; req_len = '0; grant_ready = 1'b1;
    wr_beat = 1'b0; pop = 1'b0; pop_count = '0;
    for (int i = 0; i < NR; i++) set_len(i, 8);
    #1 chk("rst_ready", req_ready, 0);
    tick(); tick();
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_glen", grant_len, 0);
    chk("rst_res", reserved, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_free", free_space, 64);
    chk("rst_err", err, 0);

    // Round-robin order with every requester asking for 8 beats.
    do_reset();
    for (int i = 0; i < NR; i++) set_len(i, 8);
    req_valid = '1; grant_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1 chk("rr_ready", req_ready, NR'(1) << (g % NR));
      push(g % NR, 8);
      tick();
      chk("rr_gv", grant_valid, 1);
      chk("rr_id", grant_id, g % NR);
      chk("rr_res", reserved, 8 * (g + 1));
      tick();
      chk("rr_gv_drop", grant_valid, 0);
    end
    req_valid = '0;

    // Insufficient space does not block a smaller request; pop frees space one cycle later.
    do_reset();
    grant_one(3, 60);
    wr_beats(60);
    chk("fill_occ", occupancy, 60);
    chk("fill_free", free_space, 4);
    set_len(0, 8); set_len(1, 4);
    req_valid = 4'b0011; grant_ready = 1'b0;
    #1 chk("sp_ready1", req_ready, 4'b0010);
    push(1, 4);
    tick();
    chk("sp_gv", grant_valid, 1);
    chk("sp_res", reserved, 4);
    req_valid = 4'b0001; grant_ready = 1'b1;
    tick();
    #1 chk("sp_blocked", req_ready, 0);
    pop = 1'b1; pop_count = 7'd8;
    #1 chk("sp_popcyc", req_ready, 0);
    tick();
    pop = 1'b0; pop_count = '0;
    chk("sp_free", free_space, 8);
    chk("sp_occ", occupancy, 52);
    #1 chk("sp_ready0", req_ready, 4'b0001);
    push(0, 8);
    tick();
    chk("sp_res2", reserved, 12);
    chk("sp_free2", free_space, 0);
    req_valid = '0;
    tick();

    // Reservation, write and pop in the same cycle.
    do_reset();
    grant_one(0, 13);
    wr_beats(10);
    chk("mix_res0", reserved, 3);
    chk("mix_occ0", occupancy, 10);
    set_len(1, 5); req_valid = 4'b0010; grant_ready = 1'b0;
    wr_beat = 1'b1; pop = 1'b1; pop_count = 7'd2;
    #1 chk("mix_ready", req_ready, 4'b0010);
    push(1, 5);
    tick();
    wr_beat = 1'b0; pop = 1'b0; pop_count = '0; req_valid = '0;
    chk("mix_res", reserved, 7);
    chk("mix_occ", occupancy, 9);
    chk("mix_free", free_space, 48);
    grant_ready = 1'b1;
    tick();
    chk("mix_done", grant_valid, 0);

    // Write with nothing reserved, and over-pop.
    do_reset();
    wr_beats(1);
    chk("wr0_res", reserved, 0);
    chk("wr0_occ", occupancy, 0);
    chk("wr0_err", err, ERR_EXP);
    do_reset();
    chk("err_clr", err, 0);
    grant_one(0, 2);
    wr_beats(2);
    chk("op_occ0", occupancy, 2);
    pop = 1'b1; pop_count = 7'd5;
    tick();
    pop = 1'b0; pop_count = '0;
    chk("op_occ", occupancy, 0);
    chk("op_free", free_space, 64);
    chk("op_err", err, ERR_EXP);

    // Illegal lengths 0 and 65 are accepted and dropped.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      set_len(2, (t == 0) ? 0 : 65);
      req_valid = 4'b0100; grant_ready = 1'b1;
      #1 chk("il_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      chk("il_gv", grant_valid, 0);
      chk("il_res", reserved, 0);
      chk("il_err", err, ERR_EXP);
      tick();
      chk("il_gv2", grant_valid, 0);
      grant_one(1, 4);
    end

    // Reset in GRANT drops the grant and rewinds the round-robin pointer.
    do_reset();
    grant_one(1, 4);
    set_len(2, 10); req_valid = 4'b0100; grant_ready = 1'b0;
    #1 chk("rg_ready", req_ready, 4'b0100);
    push(2, 10);
    tick();
    req_valid = '0;
    tick();
    chk("rg_hold_gv", grant_valid, 1);
    chk("rg_hold_id", grant_id, 2);
    chk("rg_hold_len", grant_len, 10);
    rst = 1'b1; req_valid = '1;
    for (int i = 0; i < NR; i++) set_len(i, 8);
    #1 chk("rg_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    chk("rg_gv", grant_valid, 0);
    chk("rg_res", reserved, 0);
    chk("rg_free", free_space, 64);
    #1 chk("rg_rrptr", req_ready, 4'b0001);
    push(0, 8);
    grant_ready = 1'b1;
    tick();
    chk("rg_gv2", grant_valid, 1);
    req_valid = '0;
    tick();

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_buffer_credit_arbiter.md
DMAC_BUFFER_CREDIT_ARBITER -- requirements
Module: dmac_buffer_credit_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_ELEMENTS, default 64, shared buffer capacity in beats; CW = $clog2(MAX_ELEMENTS+1), IW = $clog2(NUM_REQ).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester space reservation request, held until accepted.
REQ-006 req_len  in  NUM_REQ*CW  requested beats, requester i at bits [i*CW +: CW]; stable while req_valid is high.
REQ-007 req_ready  out  NUM_REQ  one-cycle accept pulse, at most one bit set.
REQ-008 grant_valid / grant_ready  out / in  1 / 1  grant handshake toward the burst issuer.
REQ-009 grant_id / grant_len  out  IW / CW  winner index and reserved length, stable while grant_valid is high.
REQ-010 wr_beat  in  1  one beat written into the buffer (converts 1 reserved to occupied).
REQ-011 pop / pop_count  in  1 / CW  consumer drained pop_count beats.
REQ-012 free_space / occupancy / reserved  out  CW each  MAX_ELEMENTS-reserved-occupancy / stored beats / granted-but-unwritten beats.
REQ-013 err  out  1  sticky protocol-error flag.

Function
REQ-014 FSM states: IDLE, GRANT.
REQ-015 IDLE: eligible = req_valid[i] and 1 <= len_i <= free_space; winner = first eligible at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-016 Winner found in IDLE: same cycle req_ready[winner]=1; next cycle grant_valid=1, grant_id/grant_len latched, reserved += len, state=GRANT.
REQ-017 GRANT: hold outputs; on grant_valid&&grant_ready: state=IDLE, rr_ptr=(grant_id+1) mod NUM_REQ; no new selection in that cycle.
REQ-018 Requests with len==0 or len>MAX_ELEMENTS are illegal: accepted from IDLE by round-robin as if eligible (req_ready pulse), no grant, reserved unchanged, stay IDLE, err set.
REQ-019 Eligibility uses registered free_space; space released in cycle N is usable for selection in cycle N+1.
REQ-020 No eligible request: stay IDLE, req_ready=0, rr_ptr unchanged (insufficient-space requester blocks nobody).
REQ-021 wr_beat with reserved>0 (after same-cycle reservation add): reserved-=1, occupancy+=1.
REQ-022 wr_beat with reserved==0: ignored, err set.
REQ-023 pop: occupancy -= pop_count; pop_count>occupancy saturates to 0 and sets err; pop_count==0 no-op.
REQ-024 Reservation, wr_beat and pop in one cycle all apply: reserved_next = reserved + len - wr; occupancy_next = occupancy + wr - pop_count.
REQ-025 Invariant reserved+occupancy <= MAX_ELEMENTS at all times; free_space never wraps.
REQ-026 All outputs except req_ready registered; req_ready combinational from registered state and inputs.

Reset
REQ-027 rst high: state=IDLE, rr_ptr=0, reserved=0, occupancy=0, free_space=MAX_ELEMENTS, grant_valid=0, grant_id=0, grant_len=0, err=0.
REQ-028 rst mid-GRANT drops the pending grant without handshake; req_ready=0 while rst high.

Configuration
REQ-029 Macro DMAC_BUF_ARB_ERR_EN defined: err implemented per REQ-018/022/023, cleared only by rst.
REQ-030 DMAC_BUF_ARB_ERR_EN undefined: err tied 0, no error register; illegal-case handling (rejection, ignore, saturation) otherwise identical.

Verification
REQ-031 MAX=64, all 4 requesters valid len=8, grant_ready=1 -> grant_id order 0,1,2,3,0,...; reserved steps 8,16,24,32.
REQ-032 occupancy=60, req0 len=8, req1 len=4 -> req1 granted first, req0 held; pop_count=8 -> req0 granted next arbitration cycle, never in the pop cycle.
REQ-033 reserved=3, same cycle grant len=5 + wr_beat + pop_count=2 with occupancy=10 -> reserved=7, occupancy=9, free_space=48.
REQ-034 wr_beat with reserved=0, and pop_count=5 with occupancy=2 -> reserved stays 0, occupancy=0, err=1 (0 when macro undefined).
REQ-035 req2 len=0 then len=65 -> req_ready[2] pulses, no grant_valid, err=1, reserved unchanged.
REQ-036 rst asserted in GRANT with grant_ready=0 -> next cycle grant_valid=0, reserved=0, free_space=64, rr_ptr=0.
